// File: rtl/scariv_lsu_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : scariv_lsu_issue_sched
// Brief    : LSU issue-queue ring controller: allocates at in-pointer, picks
//            oldest ready entry, retires strictly in allocation order.
// Revision : 1.0 - initial release
// ============================================================================
module scariv_lsu_issue_sched #(
  parameter int ENTRY_SIZE = 8,
  parameter int ENTRY_W    = $clog2(ENTRY_SIZE)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_disp_valid,
  output logic                  o_disp_ready,
  output logic [ENTRY_SIZE-1:0] o_put,
  input  logic [ENTRY_SIZE-1:0] i_entry_valid,
  input  logic [ENTRY_SIZE-1:0] i_entry_ready,
  input  logic                  i_pipe_stall,
  output logic                  o_issue_valid,
  output logic [ENTRY_W-1:0]    o_issue_idx,
  output logic [ENTRY_SIZE-1:0] o_entry_picked,
  input  logic [ENTRY_SIZE-1:0] i_issue_succeeded,
  output logic [ENTRY_SIZE-1:0] o_clear_entry,
  output logic [ENTRY_SIZE-1:0] o_out_ptr_valid,
  output logic [ENTRY_W:0]      o_count,
  output logic                  o_empty
);

  localparam logic [ENTRY_W:0] C_FULL = (ENTRY_W+1)'(ENTRY_SIZE);

  logic [ENTRY_W-1:0]      r_in_ptr_q, w_in_ptr_d;
  logic [ENTRY_W-1:0]      r_out_ptr_q, w_out_ptr_d;
  logic [ENTRY_W:0]        r_count_q, w_count_d;
  logic                    w_not_full;
  logic                    w_occupied;
  logic                    w_put;
  logic                    w_retire;
  logic [ENTRY_SIZE-1:0]   w_cand;
  logic [2*ENTRY_SIZE-1:0] w_cand2;
  logic [ENTRY_SIZE-1:0]   w_rot;
  logic [ENTRY_W-1:0]      w_offset;

  assign w_not_full   = (r_count_q != C_FULL);
  assign w_occupied   = (r_count_q != '0);
  // Readiness uses the registered count only, so a same-cycle clear never frees space.
  assign o_disp_ready = i_reset | w_not_full;
  assign w_put        = i_disp_valid & w_not_full & ~i_reset;
  assign w_retire     = i_issue_succeeded[r_out_ptr_q] & w_occupied & ~i_reset;

  // Rotate candidates so the out-pointer slot becomes bit 0 (oldest first).
  assign w_cand  = i_entry_valid & i_entry_ready;
  assign w_cand2 = {w_cand, w_cand};
  assign w_rot   = w_cand2[r_out_ptr_q +: ENTRY_SIZE];

  always_comb begin
    w_offset = '0;
    for (int i = ENTRY_SIZE - 1; i >= 0; i--) begin
      if (w_rot[i]) w_offset = ENTRY_W'(i);
    end
  end

  assign o_issue_idx   = r_out_ptr_q + w_offset;
  assign o_issue_valid = (|w_cand) & ~i_pipe_stall & ~i_reset;

  always_comb begin
    o_put           = '0;
    o_clear_entry   = '0;
    o_out_ptr_valid = '0;
    o_entry_picked  = '0;
    for (int i = 0; i < ENTRY_SIZE; i++) begin
      if (w_put && (r_in_ptr_q == ENTRY_W'(i)))                o_put[i]           = 1'b1;
      if (w_retire && (r_out_ptr_q == ENTRY_W'(i)))            o_clear_entry[i]   = 1'b1;
      if (!i_reset && w_occupied && (r_out_ptr_q == ENTRY_W'(i))) o_out_ptr_valid[i] = 1'b1;
      if (o_issue_valid && (o_issue_idx == ENTRY_W'(i)))       o_entry_picked[i]  = 1'b1;
    end
  end

  assign o_count = i_reset ? '0 : r_count_q;
  assign o_empty = (o_count == '0);

  always_comb begin
    w_in_ptr_d  = r_in_ptr_q + ENTRY_W'(w_put);
    w_out_ptr_d = r_out_ptr_q + ENTRY_W'(w_retire);
    w_count_d   = r_count_q;
    case ({w_put, w_retire})
      2'b10:   w_count_d = r_count_q + 1'b1;
      2'b01:   w_count_d = r_count_q - 1'b1;
      default: w_count_d = r_count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_in_ptr_q  <= '0;
      r_out_ptr_q <= '0;
      r_count_q   <= '0;
    end else begin
      r_in_ptr_q  <= w_in_ptr_d;
      r_out_ptr_q <= w_out_ptr_d;
      r_count_q   <= w_count_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (!i_reset && (r_count_q > C_FULL)) begin
      $fatal(1, "scariv_lsu_issue_sched: occupancy count out of range");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_scariv_lsu_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_scariv_lsu_issue_sched
// Brief    : Directed self-checking bench for scariv_lsu_issue_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scariv_lsu_issue_sched;

  localparam int ENTRY_SIZE = 8;
  localparam int ENTRY_W    = 3;

  logic                  clk;
  logic                  i_reset;
  logic                  i_disp_valid;
  logic                  o_disp_ready;
  logic [ENTRY_SIZE-1:0] o_put;
  logic [ENTRY_SIZE-1:0] i_entry_valid;
  logic [ENTRY_SIZE-1:0] i_entry_ready;
  logic                  i_pipe_stall;
  logic                  o_issue_valid;
  logic [ENTRY_W-1:0]    o_issue_idx;
  logic [ENTRY_SIZE-1:0] o_entry_picked;
  logic [ENTRY_SIZE-1:0] i_issue_succeeded;
  logic [ENTRY_SIZE-1:0] o_clear_entry;
  logic [ENTRY_SIZE-1:0] o_out_ptr_valid;
  logic [ENTRY_W:0]      o_count;
  logic                  o_empty;

  int total = 0;
  int bad   = 0;

  scariv_lsu_issue_sched #(.ENTRY_SIZE(ENTRY_SIZE), .ENTRY_W(ENTRY_W)) dut (
    .i_clk             (clk),
    .i_reset           (i_reset),
    .i_disp_valid      (i_disp_valid),
    .o_disp_ready      (o_disp_ready),
    .o_put             (o_put),
    .i_entry_valid     (i_entry_valid),
    .i_entry_ready     (i_entry_ready),
    .i_pipe_stall      (i_pipe_stall),
    .o_issue_valid     (o_issue_valid),
    .o_issue_idx       (o_issue_idx),
    .o_entry_picked    (o_entry_picked),
    .i_issue_succeeded (i_issue_succeeded),
    .o_clear_entry     (o_clear_entry),
    .o_out_ptr_valid   (o_out_ptr_valid),
    .o_count           (o_count),
    .o_empty           (o_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are then driven mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_disp_valid = 1'b1; i_entry_valid = 8'hFF; i_entry_ready = 8'hFF;
    i_pipe_stall = 1'b0; i_issue_succeeded = 8'hFF;
    step(); step();
    #3;
    total++; if (o_put !== 8'h00) begin bad++; $display("FAIL rst_put got=%h exp=00", o_put); end
    total++; if (o_issue_valid !== 1'b0) begin bad++; $display("FAIL rst_issue got=%b exp=0", o_issue_valid); end
    total++; if (o_entry_picked !== 8'h00) begin bad++; $display("FAIL rst_picked got=%h exp=00", o_entry_picked); end
    total++; if (o_clear_entry !== 8'h00) begin bad++; $display("FAIL rst_clear got=%h exp=00", o_clear_entry); end
    total++; if (o_disp_ready !== 1'b1 || o_empty !== 1'b1) begin bad++; $display("FAIL rst_ready_empty got=%b%b exp=11", o_disp_ready, o_empty); end
    step();
    i_reset = 1'b0; i_disp_valid = 1'b0; i_entry_valid = 8'h00; i_entry_ready = 8'h00; i_issue_succeeded = 8'h00;
    #3;
    total++; if (o_count !== 4'd0) begin bad++; $display("FAIL post_rst_count got=%0d exp=0", o_count); end
    total++; if (o_out_ptr_valid !== 8'h00) begin bad++; $display("FAIL post_rst_outptr got=%h exp=00", o_out_ptr_valid); end
    total++; if (o_clear_entry !== 8'h00) begin bad++; $display("FAIL post_rst_clear got=%h exp=00", o_clear_entry); end
    step();
  endtask

  task automatic test_alloc();
    logic [7:0] exp;
    for (int k = 0; k < 3; k++) begin
      i_disp_valid = 1'b1;
      exp = 8'h01 << k;
      #3;
      total++; if (o_put !== exp) begin bad++; $display("FAIL alloc_put%0d got=%h exp=%h", k, o_put, exp); end
      step();
    end
    i_disp_valid = 1'b0;
    #3;
    total++; if (o_count !== 4'd3) begin bad++; $display("FAIL alloc_count got=%0d exp=3", o_count); end
    total++; if (o_out_ptr_valid !== 8'h01) begin bad++; $display("FAIL alloc_outptr got=%h exp=01", o_out_ptr_valid); end
    total++; if (o_empty !== 1'b0) begin bad++; $display("FAIL alloc_empty got=%b exp=0", o_empty); end
    step();
  endtask

  task automatic test_retire_order();
    logic [7:0] exp;
    i_issue_succeeded = 8'h06;
    #3;
    total++; if (o_clear_entry !== 8'h00) begin bad++; $display("FAIL young_clear got=%h exp=00", o_clear_entry); end
    step();
    #3;
    total++; if (o_count !== 4'd3) begin bad++; $display("FAIL young_count got=%0d exp=3", o_count); end
    i_issue_succeeded = 8'h07;
    for (int k = 0; k < 3; k++) begin
      exp = 8'h01 << k;
      #1;
      total++; if (o_clear_entry !== exp) begin bad++; $display("FAIL retire_clear%0d got=%h exp=%h", k, o_clear_entry, exp); end
      step();
      #2;
    end
    total++; if (o_empty !== 1'b1 || o_count !== 4'd0) begin bad++; $display("FAIL retire_empty got=%b/%0d exp=1/0", o_empty, o_count); end
    total++; if (o_clear_entry !== 8'h00) begin bad++; $display("FAIL retire_noclear got=%h exp=00", o_clear_entry); end
    i_issue_succeeded = 8'h00;
    step();
  endtask

  task automatic test_pick();
    // {valid, ready, stall, exp_valid, exp_idx, exp_picked}; out-pointer sits at 6
    logic [7:0] tv  [7] = '{8'h41, 8'h41, 8'h03, 8'h81, 8'h41, 8'h00, 8'h30};
    logic [7:0] tr  [7] = '{8'h41, 8'h41, 8'hFF, 8'hFF, 8'h01, 8'hFF, 8'h30};
    logic       ts  [7] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0};
    logic       ev  [7] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1};
    logic [2:0] ei  [7] = '{3'd6,  3'd0,  3'd0,  3'd7,  3'd0,  3'd0,  3'd4};
    logic [7:0] ep  [7] = '{8'h40, 8'h00, 8'h01, 8'h80, 8'h01, 8'h00, 8'h10};
    // Move the ring from slot 3 to slot 6: three puts, then three retires.
    i_disp_valid = 1'b1;
    step(); step(); step();
    i_disp_valid = 1'b0; i_issue_succeeded = 8'hFF;
    step(); step(); step();
    i_issue_succeeded = 8'h00;
    #3;
    total++; if (o_count !== 4'd0) begin bad++; $display("FAIL pick_setup_count got=%0d exp=0", o_count); end
    step();
    for (int k = 0; k < 7; k++) begin
      i_entry_valid = tv[k]; i_entry_ready = tr[k]; i_pipe_stall = ts[k];
      #3;
      total++; if (o_issue_valid !== ev[k]) begin bad++; $display("FAIL pick_valid%0d got=%b exp=%b", k, o_issue_valid, ev[k]); end
      total++; if (o_entry_picked !== ep[k]) begin bad++; $display("FAIL pick_onehot%0d got=%h exp=%h", k, o_entry_picked, ep[k]); end
      if (ev[k]) begin
        total++; if (o_issue_idx !== ei[k]) begin bad++; $display("FAIL pick_idx%0d got=%0d exp=%0d", k, o_issue_idx, ei[k]); end
      end
      step();
    end
    i_entry_valid = 8'h00; i_entry_ready = 8'h00; i_pipe_stall = 1'b0;
  endtask

  task automatic test_full();
    logic [7:0] exp;
    pulse_reset();
    for (int k = 0; k < 8; k++) begin
      i_disp_valid = 1'b1;
      exp = 8'h01 << k;
      #3;
      total++; if (o_put !== exp || o_disp_ready !== 1'b1) begin bad++; $display("FAIL fill_put%0d got=%h/%b exp=%h/1", k, o_put, o_disp_ready, exp); end
      step();
    end
    #3;
    total++; if (o_count !== 4'd8) begin bad++; $display("FAIL full_count got=%0d exp=8", o_count); end
    total++; if (o_disp_ready !== 1'b0 || o_put !== 8'h00) begin bad++; $display("FAIL full_block got=%b/%h exp=0/00", o_disp_ready, o_put); end
    i_issue_succeeded = 8'h01;
    #1;
    total++; if (o_clear_entry !== 8'h01) begin bad++; $display("FAIL full_clear got=%h exp=01", o_clear_entry); end
    total++; if (o_put !== 8'h00 || o_disp_ready !== 1'b0) begin bad++; $display("FAIL full_sameclk got=%h/%b exp=00/0", o_put, o_disp_ready); end
    step();
    i_issue_succeeded = 8'h00;
    #3;
    total++; if (o_put !== 8'h01 || o_count !== 4'd7) begin bad++; $display("FAIL full_refill got=%h/%0d exp=01/7", o_put, o_count); end
    step();
    i_disp_valid = 1'b0;
    #3;
    total++; if (o_count !== 4'd8 || o_disp_ready !== 1'b0) begin bad++; $display("FAIL full_again got=%0d/%b exp=8/0", o_count, o_disp_ready); end
    step();
  endtask

  task automatic test_wrap();
    pulse_reset();
    for (int k = 0; k < 10; k++) begin
      i_disp_valid = 1'b1; i_issue_succeeded = 8'h00;
      step();
      i_disp_valid = 1'b0; i_issue_succeeded = 8'hFF;
      step();
    end
    i_issue_succeeded = 8'h00; i_disp_valid = 1'b1;
    #3;
    total++; if (o_put !== 8'h04) begin bad++; $display("FAIL wrap_put got=%h exp=04", o_put); end
    step();
    i_disp_valid = 1'b0; i_issue_succeeded = 8'hFF;
    #3;
    total++; if (o_out_ptr_valid !== 8'h04) begin bad++; $display("FAIL wrap_outptr got=%h exp=04", o_out_ptr_valid); end
    total++; if (o_clear_entry !== 8'h04) begin bad++; $display("FAIL wrap_clear got=%h exp=04", o_clear_entry); end
    step();
    i_issue_succeeded = 8'h00;
    #3;
    total++; if (o_count !== 4'd0) begin bad++; $display("FAIL wrap_count got=%0d exp=0", o_count); end
    step();
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    i_disp_valid = 1'b1;
    for (int k = 0; k < 5; k++) step();
    i_disp_valid = 1'b0;
    #3;
    total++; if (o_count !== 4'd5) begin bad++; $display("FAIL mid_pre_count got=%0d exp=5", o_count); end
    step();
    i_reset = 1'b1; i_issue_succeeded = 8'hFF; i_disp_valid = 1'b1;
    i_entry_valid = 8'hFF; i_entry_ready = 8'hFF;
    #3;
    total++; if (o_clear_entry !== 8'h00 || o_put !== 8'h00 || o_issue_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_strobes got=%h/%h/%b exp=00/00/0", o_clear_entry, o_put, o_issue_valid); end
    step();
    i_reset = 1'b0; i_issue_succeeded = 8'h00; i_disp_valid = 1'b0;
    i_entry_valid = 8'h00; i_entry_ready = 8'h00;
    #3;
    total++; if (o_count !== 4'd0 || o_empty !== 1'b1 || o_disp_ready !== 1'b1) begin bad++; $display("FAIL mid_after got=%0d/%b/%b exp=0/1/1", o_count, o_empty, o_disp_ready); end
    total++; if (o_clear_entry !== 8'h00 || o_out_ptr_valid !== 8'h00) begin bad++; $display("FAIL mid_after_strobes got=%h/%h exp=00/00", o_clear_entry, o_out_ptr_valid); end
    step();
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_retire_order();
    test_pick();
    test_full();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
